// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port among NREQ requesters.
// Optional ACCESS-phase timeout is built when APB_ARB_TIMEOUT_EN is defined.
module apb_req_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_W-1:0]     req_addr,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ*DATA_W-1:0]     req_wdata,
  input  logic [NREQ*(DATA_W/8)-1:0] req_strb,
  input  logic [NREQ*3-1:0]          req_prot,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic [ADDR_W-1:0]          paddr,
  output logic                       pwrite,
  output logic [DATA_W-1:0]          pwdata,
  output logic [DATA_W/8-1:0]        pstrb,
  output logic [2:0]                 pprot,
  output logic                       psel,
  output logic                       penable,
  input  logic                       pready,
  input  logic [DATA_W-1:0]          prdata,
  input  logic                       pslverr
);

  localparam int IDX_W  = $clog2(NREQ);
  localparam int STRB_W = DATA_W / 8;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || (DATA_W % 8) != 0) begin : g_bad_param
    $error("apb_req_arbiter: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;
  logic             gnt_found;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));
`endif

  // Search starts one past the last winner so every requester gets a turn.
  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = last;
    cand      = last;
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(last) + off >= NREQ) ? IDX_W'(int'(last) + off - NREQ)
                                        : IDX_W'(int'(last) + off);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      last      <= IDX_W'(NREQ - 1);
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
      pprot     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      // Accept and response strobes are single-cycle pulses.
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            paddr              <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
            pwrite             <= req_write[gnt_idx];
            pwdata             <= req_wdata[gnt_idx*DATA_W +: DATA_W];
            pstrb              <= req_strb[gnt_idx*STRB_W +: STRB_W];
            pprot              <= req_prot[gnt_idx*3 +: 3];
            psel               <= 1'b1;
            req_ready[gnt_idx] <= 1'b1;
            last               <= gnt_idx;
            state              <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            psel            <= 1'b0;
            penable         <= 1'b0;
            rsp_valid[last] <= 1'b1;
            rsp_rdata       <= pwrite ? '0 : prdata;
            rsp_err         <= pslverr;
            state           <= IDLE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            psel            <= 1'b0;
            penable         <= 1'b0;
            rsp_valid[last] <= 1'b1;
            rsp_err         <= 1'b1;
            state           <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: stimulus pushes expected grants and
// responses, independent monitors pop and compare them on the falling edge.
module tb_apb_req_arbiter;

  localparam int NREQ = 2;

  logic              pclk = 1'b0;
  logic              presetn;
  logic [NREQ-1:0]   req_valid, req_ready, req_write, rsp_valid;
  logic [NREQ*32-1:0] req_addr, req_wdata;
  logic [NREQ*4-1:0] req_strb;
  logic [NREQ*3-1:0] req_prot;
  logic [31:0]       rsp_rdata, paddr, pwdata, prdata;
  logic              rsp_err, pwrite, psel, penable, pready, pslverr;
  logic [3:0]        pstrb;
  logic [2:0]        pprot;

  apb_req_arbiter #(.NREQ(NREQ), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .psel(psel), .penable(penable),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [NREQ-1:0] oh;
    logic [31:0]     rdata;
    logic            err;
  } rsp_t;

  typedef struct packed {
    logic [NREQ-1:0] oh;
    logic [31:0]     addr;
  } gnt_t;

  rsp_t rsp_q[$];
  gnt_t gnt_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor
  always @(negedge pclk) begin
    if (presetn && rsp_valid != '0) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'(0));
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(e.oh));
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  // Grant monitor: the accept pulse coincides with the first SETUP cycle
  always @(negedge pclk) begin
    if (presetn && req_ready != '0) begin
      if (gnt_q.size() == 0) begin
        check("unexpected_grant", 64'(req_ready), 64'(0));
      end else begin
        gnt_t g;
        g = gnt_q.pop_front();
        check("grant_onehot", 64'(req_ready), 64'(g.oh));
        check("setup_paddr", 64'(paddr), 64'(g.addr));
        check("setup_phase", 64'({psel, penable}), 64'(2'b10));
      end
    end
  end

  task automatic set_cmd(input int id, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [2:0] prot);
    req_addr[id*32 +: 32] = addr;
    req_wdata[id*32 +: 32] = wdata;
    req_strb[id*4 +: 4]   = strb;
    req_prot[id*3 +: 3]   = prot;
    req_write[id]         = wr;
  endtask

  // Raise valid, wait (bounded) for accept, drop valid; returns in SETUP.
  task automatic start(input int id, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic [2:0] prot);
    gnt_t g;
    g.oh   = NREQ'(1) << id;
    g.addr = addr;
    gnt_q.push_back(g);
    set_cmd(id, wr, addr, wdata, strb, prot);
    req_valid[id] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge pclk);
      if (req_ready[id]) break;
    end
    check("accept_seen", 64'(req_ready[id]), 64'(1));
    req_valid[id] = 1'b0;
    check("setup_pwrite", 64'(pwrite), 64'(wr));
    if (wr) check("setup_pwdata", 64'(pwdata), 64'(wdata));
    check("setup_pstrb", 64'(pstrb), 64'(strb));
    check("setup_pprot", 64'(pprot), 64'(prot));
  endtask

  task automatic issue(input int id, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic [2:0] prot, input int waits,
                       input logic [31:0] rd, input bit err);
    rsp_t r;
    r.oh    = NREQ'(1) << id;
    r.rdata = wr ? 32'h0 : rd;
    r.err   = err;
    rsp_q.push_back(r);
    start(id, wr, addr, wdata, strb, prot);
    pready = 1'b0;
    for (int k = 1; k <= waits + 1; k++) begin
      @(negedge pclk);
      check("access_phase", 64'({psel, penable}), 64'(2'b11));
      pready  = (k == waits + 1);
      prdata  = rd;
      pslverr = err;
    end
    @(negedge pclk);
    pready  = 1'b0;
    pslverr = 1'b0;
    check("idle_after_xfer", 64'({psel, penable}), 64'(2'b00));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int span, idle_cyc, ngnt, nrsp;
    bit seen;
    presetn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (2) @(negedge pclk);
    check("rst_psel_penable", 64'({psel, penable}), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_paddr", 64'(paddr), 64'(0));
    check("rst_rsp_rdata", 64'({rsp_rdata, rsp_err}), 64'(0));
    presetn = 1'b1;
    @(negedge pclk);

    // Single write, then read with three wait states
    issue(0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 3'b000, 0, 32'h5555_5555, 1'b0);
    issue(1, 1'b0, 32'h20, 32'h0, 4'h0, 3'b001, 3, 32'hDEAD_BEEF, 1'b0);

    // Contention: last winner is 1, so order is 0,1,0,1
    for (int t = 0; t < 4; t++) begin
      gnt_t g;
      rsp_t r;
      g.oh = (t % 2 == 0) ? 2'b01 : 2'b10;
      g.addr = (t % 2 == 0) ? 32'h100 : 32'h200;
      r.oh = g.oh;
      r.rdata = (t % 2 == 0) ? 32'h0 : 32'h1234_5678;
      r.err = 1'b0;
      gnt_q.push_back(g);
      rsp_q.push_back(r);
    end
    set_cmd(0, 1'b1, 32'h100, 32'h0000_0100, 4'hF, 3'b000);
    set_cmd(1, 1'b0, 32'h200, 32'h0, 4'h0, 3'b000);
    pready = 1'b1; prdata = 32'h1234_5678;
    req_valid = 2'b11;
    span = 0; idle_cyc = 0; ngnt = 0; nrsp = 0; seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge pclk);
      if (req_ready != '0) begin
        seen = 1'b1;
        ngnt++;
        if (ngnt == 4) req_valid = '0;
      end
      if (seen) begin
        span++;
        if (!psel) idle_cyc++;
      end
      if (rsp_valid != '0) nrsp++;
      if (nrsp == 4) break;
    end
    req_valid = '0; pready = 1'b0;
    check("contention_cycles", 64'(span), 64'(12));
    check("contention_idle", 64'(idle_cyc), 64'(4));

    // Slave errors on a write and on a read
    issue(0, 1'b1, 32'h30, 32'h0BAD_0BAD, 4'h3, 3'b010, 0, 32'hFFFF_FFFF, 1'b1);
    issue(1, 1'b0, 32'h40, 32'h0, 4'h0, 3'b100, 1, 32'h0000_00C3, 1'b1);

    // Stalled slave
`ifdef APB_ARB_TIMEOUT_EN
    begin
      rsp_t r;
      r.oh = 2'b01; r.rdata = 32'h0; r.err = 1'b1;
      rsp_q.push_back(r);
    end
`endif
    start(0, 1'b0, 32'h50, 32'h0, 4'h0, 3'b000);
    pready = 1'b0; prdata = 32'h7777_7777;
`ifdef APB_ARB_TIMEOUT_EN
    span = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge pclk);
      if (!penable) break;
      span++;
    end
    check("tmo_access_cycles", 64'(span), 64'(16));
    check("tmo_psel_drop", 64'(psel), 64'(0));
    start(0, 1'b0, 32'h58, 32'h0, 4'h0, 3'b000);
    repeat (3) @(negedge pclk);
`else
    repeat (100) @(negedge pclk);
    check("no_tmo_still_access", 64'({psel, penable}), 64'(2'b11));
`endif

    // Asynchronous reset in the middle of ACCESS
    #2 presetn = 1'b0;
    #1;
    check("rst_mid_psel_penable", 64'({psel, penable}), 64'(0));
    check("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
    req_valid = '0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;

    // After reset requester 0 wins first even though it won last before
    begin
      gnt_t g0, g1;
      rsp_t r0, r1;
      g0.oh = 2'b01; g0.addr = 32'h60;
      g1.oh = 2'b10; g1.addr = 32'h70;
      r0.oh = 2'b01; r0.rdata = 32'h0; r0.err = 1'b0;
      r1.oh = 2'b10; r1.rdata = 32'h0; r1.err = 1'b0;
      gnt_q.push_back(g0); gnt_q.push_back(g1);
      rsp_q.push_back(r0); rsp_q.push_back(r1);
    end
    set_cmd(0, 1'b1, 32'h60, 32'h6666_0000, 4'hF, 3'b000);
    set_cmd(1, 1'b1, 32'h70, 32'h7070_0000, 4'hF, 3'b000);
    pready = 1'b1; prdata = 32'hFFFF_0000;
    req_valid = 2'b11;
    nrsp = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge pclk);
      if (req_ready[0]) req_valid[0] = 1'b0;
      if (req_ready[1]) req_valid[1] = 1'b0;
      if (rsp_valid != '0) nrsp++;
      if (nrsp == 2) break;
    end
    req_valid = '0; pready = 1'b0;
    check("post_rst_rsp_count", 64'(nrsp), 64'(2));

    repeat (2) @(negedge pclk);
    check("rsp_q_drained", 64'(rsp_q.size()), 64'(0));
    check("gnt_q_drained", 64'(gnt_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter and transfer sequencer that shares one APB master port among `NREQ` internal requesters (CPU bridge, DMA, debug). It accepts one command at a time and drives the APB SETUP and ACCESS phases with registered outputs, waiting on `pready`. It returns `prdata`/`pslverr` to the granted requester as a one-cycle response pulse. It sits between the requesters and the APB fabric that drives the GPIO and peer peripherals.

## Interface
- `NREQ`, 2 — number of requesters (2..8)
- `ADDR_W`, 32 — APB address width
- `DATA_W`, 32 — APB data width; `pstrb` width is `DATA_W/8`
- `TIMEOUT`, 16 — ACCESS-phase cycle limit (only with `APB_ARB_TIMEOUT_EN`)
- `pclk`  in  1  clock
- `presetn`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NREQ  command valid per requester; held until `req_ready`
- `req_ready`  out  NREQ  one-hot, one-cycle command-accept pulse
- `req_addr`  in  NREQ*ADDR_W  packed addresses, requester i at slice i
- `req_write`  in  NREQ  1 = write
- `req_wdata`  in  NREQ*DATA_W  packed write data
- `req_strb`  in  NREQ*DATA_W/8  packed byte strobes
- `req_prot`  in  NREQ*3  packed protection bits
- `rsp_valid`  out  NREQ  one-hot, one-cycle completion pulse
- `rsp_rdata`  out  DATA_W  read data, valid with `rsp_valid`; 0 for writes
- `rsp_err`  out  1  slave error or timeout, valid with `rsp_valid`
- `paddr`, `pwrite`, `pwdata`, `pstrb`, `pprot`, `psel`, `penable`  out  APB widths  APB master outputs
- `pready`, `prdata`, `pslverr`  in  APB widths  APB slave returns

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**: `psel` = `penable` = 0.
  - If any `req_valid` is high, pick grant g by round-robin. The search starts at `last+1` mod NREQ, and `last` resets to NREQ-1, so requester 0 wins first after reset.
  - Latch g's command into the APB output registers, pulse `req_ready[g]`, set `last` = g, and go to SETUP.
- **SETUP**: `psel` = 1, `penable` = 0. Always advance to ACCESS after one cycle.
- **ACCESS**: `psel` = `penable` = 1; address, data and control are held stable.
  - While `pready` = 0, stay in ACCESS and extend wait states.
  - On `pready` = 1: register `rsp_valid[g]` = 1, `rsp_rdata` = `prdata` (read) or 0 (write), `rsp_err` = `pslverr`. Go to IDLE.
- `req_valid` is sampled only in IDLE. A requester that drops valid before its accept is simply not granted.
- A requester may reissue its next command while its response pulse is high. The command is arbitrated in the following IDLE cycle.
- All outputs are registered. Reset clears the FSM to IDLE, `last` to NREQ-1, and every output to 0.
- Reset mid-transfer clears `psel`/`penable` immediately (asynchronously). No response is issued, and the requester must resend the command.

## Timing
- Minimum transfer is 3 cycles: IDLE accept, then SETUP, then ACCESS with `pready` = 1.
- `rsp_valid` is high in the cycle after `pready` is sampled high, which coincides with IDLE.
- Back-to-back throughput is one transfer per 3 cycles plus wait states. There is always at least one IDLE cycle with `psel` = 0 between transfers.
- `req_ready[g]` is high in the same cycle the FSM leaves IDLE. `paddr` is valid from the first SETUP cycle.
- If all requesters are continuously valid, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 transfers.

## Configuration
- `APB_ARB_TIMEOUT_EN`
  - **Defined**: a counter clears on entry to ACCESS and increments each ACCESS cycle with `pready` = 0. When it reaches `TIMEOUT`, the FSM aborts to IDLE: `psel`/`penable` drop, `rsp_valid[g]` = 1, `rsp_err` = 1, `rsp_rdata` = 0. A `pready` arriving on the same cycle as the limit wins, giving a normal completion.
  - **Undefined**: no counter is built, and ACCESS waits on `pready` indefinitely.

## Test plan
- **Single write**: req0 write addr 0x10, data 0xA5A5_0001, strb 0xF, `pready` tied 1 → SETUP then ACCESS, each 1 cycle with the correct APB fields; `rsp_valid` = 2'b01, `rsp_err` = 0, `rsp_rdata` = 0.
- **Read with waits**: req1 read 0x20, `pready` low 3 ACCESS cycles, `prdata` = 0xDEAD_BEEF → ACCESS lasts 4 cycles, then `rsp_valid` = 2'b10 with `rsp_rdata` = 0xDEAD_BEEF.
- **Contention**: req0 and req1 both valid continuously for 4 transfers → grant order 0,1,0,1 with one IDLE cycle between transfers.
- **Slave error**: `pslverr` = 1 with `pready` → `rsp_err` = 1 with the response pulse.
- **Timeout**: with the macro defined, TIMEOUT = 16, `pready` held 0 → abort after 16 ACCESS cycles, `rsp_err` = 1, `psel` = 0 next cycle. Without the macro → still in ACCESS at cycle 100.
- **Reset mid-ACCESS**: assert `presetn` low → `psel`/`penable` = 0 immediately, no `rsp_valid`. After release, requester 0 wins the first grant.
